dmem_line_responder: RTL



---
 rtl/dmem_line_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_line_responder.sv
// Line-organised data memory answering dcache line reads/writes with a fixed-latency one-cycle ack.
// Define DMEM_PROTOCOL_CHECK_EN to build the sticky requester-protocol checker behind err_o.
module dmem_line_responder #(
   parameter int LINE_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              err_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [LINE_W-1:0]  wdata_q;
   logic [LINE_W-1:0]  data_q;
   logic [LINE_W-1:0]  mem_q [DEPTH];

   logic               commit;
   logic               c_wr;
   logic [IDX_W-1:0]   c_idx;
   logic [LINE_W-1:0]  c_data;
   logic [IDX_W-1:0]   addr_idx;
   logic               unused_addr;

   assign addr_idx    = addr_i[5 +: IDX_W];
   assign unused_addr = ^addr_i;

   // commit marks the edge that enters ACK; the c_* mux lets LATENCY=1 commit straight from the inputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      c_wr    = wr_q;
      c_idx   = idx_q;
      c_data  = wdata_q;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               if (LATENCY == 1) begin
                  state_d = ACK;
                  commit  = 1'b1;
                  c_wr    = write_i;
                  c_idx   = addr_idx;
                  c_data  = data_i;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ACK;
               commit  = 1'b1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit && !c_wr) data_q <= mem_q[c_idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == IDLE && enable_i) begin
         wr_q    <= write_i;
         idx_q   <= addr_idx;
         wdata_q <= data_i;
      end
   end

   // Array is deliberately not reset; an aborted write simply never reaches it
   always_ff @(posedge clk_i) begin
      if (!rst_i && commit && c_wr) mem_q[c_idx] <= c_data;
   end

   assign ack_o  = (state_q == ACK);
   assign data_o = data_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
   logic err_q;
   logic viol;

   assign viol = (state_q == BUSY) &&
                 (!enable_i || (write_i != wr_q) || (addr_idx != idx_q) ||
                  (wr_q && (data_i != wdata_q)));

   always_ff @(posedge clk_i) begin
      if (rst_i)     err_q <= 1'b0;
      else if (viol) err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
